// File: rtl/latch_mem_pkg.sv
// Shared types and constants for the latch memory controller.
// Provides the controller state encoding, default geometry and a DEPTH helper.
// No logic; imported by the controller top.
package latch_mem_pkg;

    // Default geometry: 4 words of 8 bits.
    localparam int LM_DW = 8;
    localparam int LM_AW = 2;

    // Controller states. Writes walk SETUP -> PULSE -> HOLD -> DONE, reads
    // go READ -> DONE; every sequence starts and ends in IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } lm_state_t;

    // Number of words addressed by an AW-bit address.
    function automatic int lm_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/latch_mem_ctrl_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: req0/req1 requests in, last = id granted most recently (register kept
// by the parent), gnt_vld = any request, gnt_id = winning requester.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_vld,
    output logic gnt_id
);

    // Requester 1 wins when it is alone, or when both ask and requester 0
    // was the one served last time. Otherwise requester 0 wins (or nobody
    // asks, in which case gnt_id is don't-care and reads as 0).
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/latch_mem_ctrl.sv
// Sequencer and 2-port round-robin arbiter for a latch-based word memory.
// Ports: req/we/addr/wdata per requester in, done pulse per requester out,
// registered rdata, busy, registered latch enables/data out, latch outputs in.
module latch_mem_ctrl
    import latch_mem_pkg::*;
#(
    parameter int DW = LM_DW,
    parameter int AW = LM_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [AW-1:0]             addr0,
    input  logic [AW-1:0]             addr1,
    input  logic [DW-1:0]             wdata0,
    input  logic [DW-1:0]             wdata1,
    output logic                      done0,
    output logic                      done1,
    output logic [DW-1:0]             rdata,
    output logic                      busy,
    output logic [lm_depth(AW)-1:0]   lat_en,
    output logic [DW-1:0]             lat_d,
    input  logic [lm_depth(AW)*DW-1:0] lat_q
);

    localparam int DEPTH = lm_depth(AW);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lm_state_t         state_q,  state_d;
    logic              id_q,     id_d;      // granted requester
    logic [AW-1:0]     addr_q,   addr_d;    // granted word address
    logic              last_q,   last_d;    // requester served last
    logic [DEPTH-1:0]  lat_en_q, lat_en_d;
    logic [DW-1:0]     lat_d_q,  lat_d_d;   // doubles as the registered wdata
    logic [DW-1:0]     rdata_q,  rdata_d;
    logic              done0_q,  done0_d;
    logic              done1_q,  done1_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic gnt_vld;
    logic gnt_id;

    rr_arb2 u_arb (
        .req0    (req0),
        .req1    (req1),
        .last    (last_q),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // Operands of whichever requester wins in IDLE.
    logic          gnt_we;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;

    always_comb begin
        gnt_we    = gnt_id ? we1    : we0;
        gnt_addr  = gnt_id ? addr1  : addr0;
        gnt_wdata = gnt_id ? wdata1 : wdata0;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // Every latch-facing output is computed here one cycle early and then
    // registered, so the gates see flop outputs only and cannot glitch.
    // The write/read direction is not kept in a register: after the grant
    // it is implied by which branch of the state machine is active.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        last_d   = last_q;
        lat_en_d = '0;
        lat_d_d  = lat_d_q;
        rdata_d  = rdata_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    id_d   = gnt_id;
                    addr_d = gnt_addr;
                    if (gnt_we) begin
                        // Data is presented from the SETUP cycle onward.
                        lat_d_d = gnt_wdata;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_SETUP: begin
                // Open exactly one word gate for the following cycle.
                lat_en_d = DEPTH'(1) << addr_q;
                state_d  = ST_PULSE;
            end

            ST_PULSE: begin
                // lat_en_d defaults to zero: the gate closes while lat_d
                // is still held, giving the latch its hold margin.
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                done0_d = ~id_q;
                done1_d =  id_q;
                state_d = ST_DONE;
            end

            ST_READ: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (addr_q == AW'(i)) begin
                        rdata_d = lat_q[i*DW +: DW];
                    end
                end
                done0_d = ~id_q;
                done1_d =  id_q;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                last_d  = id_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Asynchronous reset clears lat_en immediately, so a reset landing in
    // the PULSE cycle closes the gate without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            id_q     <= 1'b0;
            addr_q   <= '0;
            last_q   <= 1'b1;
            lat_en_q <= '0;
            lat_d_q  <= '0;
            rdata_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            lat_en_q <= lat_en_d;
            lat_d_q  <= lat_d_d;
            rdata_q  <= rdata_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        lat_en = lat_en_q;
        lat_d  = lat_d_q;
        rdata  = rdata_q;
        done0  = done0_q;
        done1  = done1_q;
        busy   = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_latch_mem_ctrl.sv
// Bench for latch_mem_ctrl with a behavioural latch array and reference model.
// Latency in edges after the request is seen: write 4, read 2.
// Requesters hold req until done, then release it.
module tb_latch_mem_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic                  clk;
    logic                  rst;
    logic                  req0, req1;
    logic                  we0, we1;
    logic [AW-1:0]         addr0, addr1;
    logic [DW-1:0]         wdata0, wdata1;
    logic                  done0, done1;
    logic [DW-1:0]         rdata;
    logic                  busy;
    logic [DEPTH-1:0]      lat_en;
    logic [DW-1:0]         lat_d;
    logic [DEPTH*DW-1:0]   lat_q;

    int checks = 0;
    int errors = 0;

    // Reference model: expected memory contents and expected held rdata.
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_rdata;

    latch_mem_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .done0  (done0),
        .done1  (done1),
        .rdata  (rdata),
        .busy   (busy),
        .lat_en (lat_en),
        .lat_d  (lat_d),
        .lat_q  (lat_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gated-D latch array: transparent while its enable is high.
    logic [DW-1:0] lat_mem [DEPTH];

    always @(lat_en or lat_d) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (lat_en[i]) lat_mem[i] = lat_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) lat_q[i*DW +: DW] = lat_mem[i];
    end

    // One complete transaction from an idle controller; the request is seen
    // at the first rising edge after entry.
    task automatic run_one(input int id, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        int              exp_k;
        bit              got;
        logic            dn, dn_o;
        logic [DEPTH-1:0] exp_en;
        exp_k = we ? 4 : 2;
        got   = 1'b0;
        if (id == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        for (int k = 1; k <= 12 && !got; k++) begin
            @(posedge clk); #1;
            dn     = (id == 0) ? done0 : done1;
            dn_o   = (id == 0) ? done1 : done0;
            exp_en = (we && k == 2) ? (4'b0001 << a) : 4'b0000;
            checks++;
            if (lat_en !== exp_en) begin
                errors++;
                $display("FAIL lat_en id=%0d we=%0d k=%0d got=%b exp=%b", id, we, k, lat_en, exp_en);
            end
            checks++;
            if (dn_o !== 1'b0) begin
                errors++;
                $display("FAIL other_done id=%0d k=%0d got=%b exp=0", id, k, dn_o);
            end
            if (k <= exp_k) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_active id=%0d k=%0d got=%b exp=1", id, k, busy);
                end
            end
            if (we && k <= 3) begin
                checks++;
                if (lat_d !== d) begin
                    errors++;
                    $display("FAIL lat_d id=%0d k=%0d got=%h exp=%h", id, k, lat_d, d);
                end
            end
            if (dn === 1'b1) begin
                got = 1'b1;
                checks++;
                if (k != exp_k) begin
                    errors++;
                    $display("FAIL latency id=%0d we=%0d got=%0d exp=%0d", id, we, k, exp_k);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout id=%0d we=%0d addr=%0d got=none exp=done", id, we, a);
        end else if (we) begin
            exp_mem[a] = d;
            checks++;
            if (rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rdata_hold addr=%0d got=%h exp=%h", a, rdata, exp_rdata);
            end
        end else begin
            exp_rdata = exp_mem[a];
            checks++;
            if (rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rdata addr=%0d got=%h exp=%h", a, rdata, exp_rdata);
            end
        end
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done0, done1} !== 3'b000) begin
            errors++;
            $display("FAIL back_to_idle busy/done0/done1 got=%b exp=000", {busy, done0, done1});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done0, done1, busy, lat_en, lat_d, rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b%b%b %b %h %h exp=all zero",
                         i, done0, done1, busy, lat_en, lat_d, rdata);
            end
        end
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        run_one(0, 1'b1, 2'd0, 8'h3C);
    endtask

    task automatic test_write();
        run_one(0, 1'b1, 2'd2, 8'hA5);
    endtask

    task automatic test_read_after_write();
        run_one(1, 1'b0, 2'd2, 8'h00);
        checks++;
        if (rdata !== 8'hA5) begin
            errors++;
            $display("FAIL read_after_write got=%h exp=a5", rdata);
        end
    endtask

    task automatic test_contention();
        int  n, cyc, prev, gid, exp_id, last_m;
        // Leave the round-robin pointer at 0 so reset must restore it.
        run_one(0, 1'b1, 2'd0, 8'h77);
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 8'h33;
        @(posedge clk); #1;
        checks++;
        if ({busy, lat_en} !== '0) begin
            errors++;
            $display("FAIL contention_reset busy/lat_en got=%b %b exp=0 0", busy, lat_en);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        last_m = 1;
        n = 0; cyc = 0; prev = 0;
        while (n < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            checks++;
            if ((done0 & done1) !== 1'b0) begin
                errors++;
                $display("FAIL done_overlap cyc=%0d got=11 exp=not both", cyc);
            end
            checks++;
            if ($countones(lat_en) > 1) begin
                errors++;
                $display("FAIL lat_en_onehot cyc=%0d got=%b exp=at most one bit", cyc, lat_en);
            end
            if (done0 === 1'b1 || done1 === 1'b1) begin
                gid    = (done1 === 1'b1) ? 1 : 0;
                exp_id = 1 - last_m;
                checks++;
                if (gid != exp_id) begin
                    errors++;
                    $display("FAIL grant_order n=%0d got=%0d exp=%0d", n, gid, exp_id);
                end
                checks++;
                if ((n == 0 && cyc != 4) || (n > 0 && cyc - prev != 5)) begin
                    errors++;
                    $display("FAIL grant_spacing n=%0d got=%0d exp=%0d", n,
                             (n == 0) ? cyc : cyc - prev, (n == 0) ? 4 : 5);
                end
                if (gid == 0) exp_mem[1] = 8'h11; else exp_mem[3] = 8'h33;
                last_m = gid;
                prev   = cyc;
                n++;
            end
        end
        checks++;
        if (n < 4) begin
            errors++;
            $display("FAIL contention_timeout got=%0d dones exp=4", n);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        run_one(0, 1'b0, 2'd1, 8'h00);
        run_one(1, 1'b0, 2'd3, 8'h00);
    endtask

    task automatic test_reset_mid_pulse();
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'hC3;
        @(posedge clk); #1;   // SETUP
        @(posedge clk); #1;   // PULSE
        checks++;
        if (lat_en !== 4'b0001) begin
            errors++;
            $display("FAIL pulse_before_reset got=%b exp=0001", lat_en);
        end
        #2;
        rst  = 1'b1;
        req0 = 1'b0;
        #1;
        checks++;
        if ({lat_en, busy, done0, done1} !== '0) begin
            errors++;
            $display("FAIL async_reset lat_en/busy/done got=%b %b%b%b exp=0", lat_en, busy, done0, done1);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done0, done1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_done cyc=%0d got=%b exp=00", i, {done0, done1});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done0} !== 2'b00) begin
            errors++;
            $display("FAIL after_reset busy/done0 got=%b exp=00", {busy, done0});
        end
        run_one(0, 1'b1, 2'd0, 8'h5A);
        run_one(1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_sweep();
        for (int a = 0; a < DEPTH; a++) begin
            run_one(a % 2, 1'b1, AW'(a), 8'(8'h10 + a));
            run_one(1 - (a % 2), 1'b0, AW'(a), 8'h00);
        end
        // Every word still holds its own value after all the other writes.
        for (int a = 0; a < DEPTH; a++) begin
            run_one(0, 1'b0, AW'(a), 8'h00);
            checks++;
            if (rdata !== 8'(8'h10 + a)) begin
                errors++;
                $display("FAIL sweep_word addr=%0d got=%h exp=%h", a, rdata, 8'(8'h10 + a));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            run_one(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    AW'($urandom_range(DEPTH - 1, 0)), 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_write();
        test_read_after_write();
        test_contention();
        test_reset_mid_pulse();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
